fifo_sync_flags: RTL and testbench

Single-clock, parametrised successor to the team's fifo1 buffer. It adds a runtime occupancy count, almost-full and almost-empty thresholds, a synchronous flush, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. It sits between a same-clock producer and consumer in datapaths that do not need clock-domain crossing.

---
 rtl/fifo_sync_flags.sv | 115 +++++++++++
 tb/tb_fifo_sync_flags.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// synchronous flush, sticky error flags and selectable FWFT read mode.
module fifo_sync_flags #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  input  logic             flush,
  input  logic             err_clr,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_C = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AF_C = (ASIZE+1)'(AFULL_TH);
  localparam logic [ASIZE:0] AE_C = (ASIZE+1)'(AEMPTY_TH);

  generate
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_af
      $error("AFULL_TH must lie in 1..DEPTH");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_ae
      $error("AEMPTY_TH must lie in 0..DEPTH-1");
    end
  endgenerate

  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [ASIZE-1:0] wptr_q, wptr_d;
  logic [ASIZE-1:0] rptr_q, rptr_d;
  logic [ASIZE:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wr_ok, rd_ok;

  assign wfull         = (count_q == DEPTH_C);
  assign rempty        = (count_q == '0);
  assign walmost_full  = (count_q >= AF_C);
  assign ralmost_empty = (count_q <= AE_C);
  assign count         = count_q;
  assign overflow      = ovf_q;
  assign underflow     = udf_q;

  assign wr_ok = winc && !wfull && !flush;
  assign rd_ok = rinc && !rempty && !flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_ok) wptr_d = wptr_q + 1'b1;
      if (rd_ok) rptr_d = rptr_q + 1'b1;
      unique case (1'b1)
        (wr_ok && !rd_ok): count_d = count_q + 1'b1;
        (rd_ok && !wr_ok): count_d = count_q - 1'b1;
        default:           count_d = count_q;
      endcase
    end
    // A fresh error beats a clear arriving in the same cycle
    ovf_d = (ovf_q && !err_clr) || (winc && wfull && !flush);
    udf_d = (udf_q && !err_clr) || (rinc && rempty && !flush);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q] <= wdata;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata = mem_q[rptr_q];
    end else begin : g_reg
      logic [DSIZE-1:0] rdata_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rdata_q <= '0;
        else if (rd_ok) rdata_q <= mem_q[rptr_q];
      end
      assign rdata = rdata_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Scoreboard bench: registered-read and FWFT instances driven with
// directed vectors; read data checked by decoupled monitors.
module tb_fifo_sync_flags;

  logic       clk = 1'b0;
  logic       rst_n;
  int         n_cmp = 0;
  int         n_bad = 0;

  logic       w0, r0, fl0, ec0;
  logic [7:0] wd0, rd0;
  logic       full0, emp0, af0, ae0, ov0, un0;
  logic [4:0] cnt0;

  logic       w1, r1, fl1, ec1;
  logic [7:0] wd1, rd1;
  logic       full1, emp1, af1, ae1, ov1, un1;
  logic [4:0] cnt1;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       pend0 = 1'b0;

  always #5 clk = ~clk;

  fifo_sync_flags #(
    .DSIZE(8), .ASIZE(4), .FWFT(0),
    .AFULL_TH(12), .AEMPTY_TH(2)
  ) dut0 (
    .clk(clk), .rst_n(rst_n),
    .winc(w0), .wdata(wd0),
    .rinc(r0), .rdata(rd0),
    .flush(fl0), .err_clr(ec0),
    .wfull(full0), .rempty(emp0),
    .walmost_full(af0), .ralmost_empty(ae0),
    .count(cnt0),
    .overflow(ov0), .underflow(un0)
  );

  fifo_sync_flags #(
    .DSIZE(8), .ASIZE(4), .FWFT(1),
    .AFULL_TH(12), .AEMPTY_TH(2)
  ) dut1 (
    .clk(clk), .rst_n(rst_n),
    .winc(w1), .wdata(wd1),
    .rinc(r1), .rdata(rd1),
    .flush(fl1), .err_clr(ec1),
    .wfull(full1), .rempty(emp1),
    .walmost_full(af1), .ralmost_empty(ae1),
    .count(cnt1),
    .overflow(ov1), .underflow(un1)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic st0(input string t, input int c,
                     input logic f, input logic e,
                     input logic af, input logic ae,
                     input logic ov, input logic un);
    chk({t, " count"}, 32'(cnt0), c);
    chk({t, " wfull"}, 32'(full0), 32'(f));
    chk({t, " rempty"}, 32'(emp0), 32'(e));
    chk({t, " afull"}, 32'(af0), 32'(af));
    chk({t, " aempty"}, 32'(ae0), 32'(ae));
    chk({t, " ovf"}, 32'(ov0), 32'(ov));
    chk({t, " udf"}, 32'(un0), 32'(un));
  endtask

  // Registered read: data is valid the cycle after an accepted pop
  always @(negedge clk) begin
    if (pend0) begin
      if (q0.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rd0 unexpected pop: got %0h", rd0);
      end else begin
        chk("rd0 data", 32'(rd0), 32'(q0.pop_front()));
      end
    end
    pend0 = rst_n && r0 && !emp0 && !fl0;
  end

  // FWFT: head word is visible before the popping edge
  always @(negedge clk) begin
    if (rst_n && r1 && !emp1 && !fl1) begin
      if (q1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rd1 unexpected pop: got %0h", rd1);
      end else begin
        chk("rd1 data", 32'(rd1), 32'(q1.pop_front()));
      end
    end
  end

  task automatic fill0(input int base);
    for (int i = 1; i <= 16; i++) begin
      w0 = 1'b1; wd0 = 8'(base + i);
      tick();
      chk("fill count", 32'(cnt0), i);
      chk("fill afull", 32'(af0), 32'(i >= 12));
      chk("fill wfull", 32'(full0), 32'(i == 16));
    end
    w0 = 1'b0;
  endtask

  task automatic drain0(input int first, input int n,
                        input int start_cnt);
    for (int i = 0; i < n; i++) begin
      q0.push_back(8'(first + i));
      r0 = 1'b1;
      tick();
      chk("drain count", 32'(cnt0), start_cnt - i - 1);
      chk("drain aempty", 32'(ae0),
          32'((start_cnt - i - 1) <= 2));
    end
    r0 = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    {w0, r0, fl0, ec0} = '0; wd0 = '0;
    {w1, r1, fl1, ec1} = '0; wd1 = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    st0("reset", 0, 0, 1, 0, 1, 0, 0);
    chk("reset rdata", 32'(rd0), 0);
    chk("reset cnt1", 32'(cnt1), 0);
    chk("reset emp1", 32'(emp1), 1);

    // Single word through registered read
    w0 = 1'b1; wd0 = 8'd10;
    tick();
    w0 = 1'b0;
    st0("one wr", 1, 0, 0, 0, 1, 0, 0);
    drain0(10, 1, 1);
    chk("one rdata", 32'(rd0), 10);

    // Three full/overflow/drain rounds exercise pointer wrap
    for (int rnd = 0; rnd < 3; rnd++) begin
      fill0(0);
      w0 = 1'b1; wd0 = 8'd99;
      tick();
      w0 = 1'b0;
      st0("ovf", 16, 1, 0, 1, 0, 1, 0);
      ec0 = 1'b1;
      tick();
      ec0 = 1'b0;
      chk("ovf clr", 32'(ov0), 0);
      drain0(1, 16, 16);
    end

    // Full with simultaneous write+read: only the read lands
    fill0(20);
    q0.push_back(8'd21);
    w0 = 1'b1; r0 = 1'b1; wd0 = 8'd77;
    tick();
    w0 = 1'b0; r0 = 1'b0;
    st0("full wr+rd", 15, 0, 0, 1, 0, 1, 0);
    drain0(22, 7, 15);
    q0.push_back(8'd29);
    w0 = 1'b1; r0 = 1'b1; wd0 = 8'd50;
    tick();
    w0 = 1'b0; r0 = 1'b0;
    chk("mid wr+rd count", 32'(cnt0), 8);
    drain0(30, 7, 8);
    drain0(50, 1, 1);
    ec0 = 1'b1;
    tick();
    ec0 = 1'b0;

    // Flush beats a concurrent write and raises no error
    for (int i = 0; i < 7; i++) begin
      w0 = 1'b1; wd0 = 8'(100 + i);
      tick();
    end
    w0 = 1'b0;
    chk("pre flush", 32'(cnt0), 7);
    fl0 = 1'b1; w0 = 1'b1; wd0 = 8'hEE;
    tick();
    fl0 = 1'b0; w0 = 1'b0;
    st0("flush", 0, 0, 1, 0, 1, 0, 0);
    chk("flush rdata", 32'(rd0), 50);
    r0 = 1'b1;
    tick();
    r0 = 1'b0;
    chk("udf0", 32'(un0), 1);

    // FWFT head visibility, pop, underflow and clear races
    w1 = 1'b1; wd1 = 8'hA5;
    tick();
    chk("fwft emp", 32'(emp1), 0);
    chk("fwft head", 32'(rd1), 32'hA5);
    wd1 = 8'hB6;
    tick();
    w1 = 1'b0;
    q1.push_back(8'hA5);
    r1 = 1'b1;
    tick();
    r1 = 1'b0;
    chk("fwft next", 32'(rd1), 32'hB6);
    chk("fwft cnt", 32'(cnt1), 1);
    q1.push_back(8'hB6);
    r1 = 1'b1;
    tick();
    chk("fwft cnt0", 32'(cnt1), 0);
    chk("fwft no udf", 32'(un1), 0);
    tick();
    r1 = 1'b0;
    chk("fwft udf", 32'(un1), 1);
    ec1 = 1'b1;
    tick();
    chk("fwft udf clr", 32'(un1), 0);
    r1 = 1'b1;
    tick();
    r1 = 1'b0; ec1 = 1'b0;
    chk("fwft set wins", 32'(un1), 1);

    // Asynchronous reset in the middle of a write burst
    for (int i = 0; i < 5; i++) begin
      w0 = 1'b1; wd0 = 8'(60 + i);
      w1 = 1'b1; wd1 = 8'(70 + i);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    st0("async rst", 0, 0, 1, 0, 1, 0, 0);
    chk("async rst rdata", 32'(rd0), 0);
    chk("async rst cnt1", 32'(cnt1), 0);
    chk("async rst udf1", 32'(un1), 0);
    w0 = 1'b0; w1 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();

    chk("q0 drained", 32'(q0.size()), 0);
    chk("q1 drained", 32'(q1.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
